// File: rtl/writeback_stage.sv
// Final pipeline stage: commits execute results to the register file or data memory,
// owns the architectural flags, and retires instructions over a valid/ready handshake.
module writeback_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            opcode,
    input  logic [REG_AW-1:0]     rd,
    input  logic [MEM_AW-1:0]     mem_addr,
    input  logic [2*DATA_W-1:0]   result,
    input  logic                  zero_in,
    input  logic                  carry_in,
    input  logic                  ac_in,
    input  logic                  parity_in,
    output logic                  reg_we,
    output logic [REG_AW-1:0]     reg_waddr,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            flags,
    output logic                  cmp_flag,
    output logic                  wb_done,
    output logic                  halted
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_LO = 2'd1;
    localparam logic [1:0] WR_HI = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [4:0] OP_STORE = 5'b01100;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    function automatic logic is_reg_op(input logic [4:0] op);
        return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00101, 5'b00110,
                          5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                          [5'b10000:5'b10101]};
    endfunction

    function automatic logic is_two_cycle(input logic [4:0] op);
        return op inside {5'b00011, 5'b00100};
    endfunction

    function automatic logic upd_carry(input logic [4:0] op);
        return op inside {5'b00001, 5'b00010, 5'b00101, 5'b00110, [5'b10000:5'b10011]};
    endfunction

    function automatic logic upd_ac(input logic [4:0] op);
        return op inside {5'b00001, 5'b00010, 5'b00101, 5'b00110};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] res_hi_q, res_hi_d;
    logic              reg_we_q, reg_we_d;
    logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        flags_q, flags_d;
    logic              cmp_q, cmp_d;
    logic              wb_done_q, wb_done_d;
    logic              accept;

    // A latched two-cycle op or halt blocks the next instruction; reset also deasserts ready.
    assign in_ready = !reset &&
                      ((state_q == IDLE) ||
                       (state_q == WR_LO && !is_two_cycle(op_q) && op_q != OP_HALT));
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        res_hi_d    = res_hi_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        flags_d     = flags_q;
        cmp_d       = cmp_q;
        wb_done_d   = 1'b0;

        case (state_q)
            WR_LO: begin
                if (is_two_cycle(op_q)) begin
                    state_d     = WR_HI;
                    reg_we_d    = 1'b1;
                    reg_waddr_d = rd_q + REG_AW'(1);
                    reg_wdata_d = res_hi_q;
                    wb_done_d   = 1'b1;
                end else if (op_q == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI:   state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A new accept overrides the WR_LO -> IDLE return so single-cycle ops stream.
        if (accept) begin
            state_d   = WR_LO;
            op_d      = opcode;
            rd_d      = rd;
            res_hi_d  = result[2*DATA_W-1:DATA_W];
            wb_done_d = !is_two_cycle(opcode);
            if (is_reg_op(opcode) || is_two_cycle(opcode)) begin
                reg_we_d    = 1'b1;
                reg_waddr_d = rd;
                reg_wdata_d = result[DATA_W-1:0];
            end
            if (opcode == OP_STORE) begin
                mem_we_d    = 1'b1;
                mem_waddr_d = mem_addr;
                mem_wdata_d = result[DATA_W-1:0];
            end
            if (is_reg_op(opcode) || is_two_cycle(opcode) || opcode == OP_STORE) begin
                flags_d[3] = zero_in;
                flags_d[0] = parity_in;
            end
            if (upd_carry(opcode)) flags_d[2] = carry_in;
            if (upd_ac(opcode))    flags_d[1] = ac_in;
            if (opcode == OP_CMP)  cmp_d      = result[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            res_hi_q    <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            flags_q     <= '0;
            cmp_q       <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            res_hi_q    <= res_hi_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            flags_q     <= flags_d;
            cmp_q       <= cmp_d;
            wb_done_q   <= wb_done_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign flags     = flags_q;
    assign cmp_flag  = cmp_q;
    assign wb_done   = wb_done_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the stimulus thread queues hand-computed writes and
// retirements, and a negedge monitor pops and compares whenever the DUT writes or retires.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [3:0]  mem_addr;
    logic [15:0] result;
    logic        zero_in, carry_in, ac_in, parity_in;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [3:0]  flags;
    logic        cmp_flag;
    logic        wb_done;
    logic        halted;

    writeback_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .mem_addr(mem_addr), .result(result),
        .zero_in(zero_in), .carry_in(carry_in), .ac_in(ac_in), .parity_in(parity_in),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flags(flags), .cmp_flag(cmp_flag), .wb_done(wb_done), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_mem;
        logic [3:0] addr;
        logic [7:0] data;
        logic       done;
    } wr_t;

    typedef struct {
        logic [3:0] flags;
        logic       cmp;
    } ret_t;

    wr_t  wr_q[$];
    ret_t ret_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write or retirement must match the oldest queued expectation.
    initial begin
        wr_t  w;
        ret_t r;
        forever begin
            @(negedge clk);
            if (reg_we || mem_we) begin
                check("we_exclusive", {31'd0, reg_we & mem_we}, 32'd0);
                check("write_expected", {31'd0, wr_q.size() > 0}, 32'd1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    check("write_kind", {31'd0, mem_we}, {31'd0, w.is_mem});
                    if (w.is_mem) begin
                        check("mem_waddr", {28'd0, mem_waddr}, {28'd0, w.addr});
                        check("mem_wdata", {24'd0, mem_wdata}, {24'd0, w.data});
                    end else begin
                        check("reg_waddr", {29'd0, reg_waddr}, {28'd0, w.addr});
                        check("reg_wdata", {24'd0, reg_wdata}, {24'd0, w.data});
                    end
                    check("write_done", {31'd0, wb_done}, {31'd0, w.done});
                end
            end
            if (wb_done) begin
                check("retire_expected", {31'd0, ret_q.size() > 0}, 32'd1);
                if (ret_q.size() > 0) begin
                    r = ret_q.pop_front();
                    check("retire_flags", {28'd0, flags}, {28'd0, r.flags});
                    check("retire_cmp", {31'd0, cmp_flag}, {31'd0, r.cmp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // wk: 0 no write, 1 register write, 2 memory write, 3 two-cycle register write.
    task automatic send(input logic [4:0] op, input logic [2:0] r, input logic [3:0] ma,
                        input logic [15:0] res, input logic [3:0] fi, input int wk,
                        input logic [3:0] a1, input logic [7:0] d1,
                        input logic [3:0] a2, input logic [7:0] d2,
                        input logic [3:0] ef, input logic ec, output int waits);
        logic rdy;
        opcode   = op;
        rd       = r;
        mem_addr = ma;
        result   = res;
        {zero_in, carry_in, ac_in, parity_in} = fi;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 20) begin
                check("accept_timeout", waits, 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
        if (wk == 1) wr_q.push_back('{1'b0, a1, d1, 1'b1});
        if (wk == 2) wr_q.push_back('{1'b1, a1, d1, 1'b1});
        if (wk == 3) begin
            wr_q.push_back('{1'b0, a1, d1, 1'b0});
            wr_q.push_back('{1'b0, a2, d2, 1'b1});
        end
        ret_q.push_back('{ef, ec});
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_we"},   {31'd0, reg_we}, 32'd0);
        check({tag, "_mem_we"},   {31'd0, mem_we}, 32'd0);
        check({tag, "_reg_addr"}, {29'd0, reg_waddr}, 32'd0);
        check({tag, "_reg_data"}, {24'd0, reg_wdata}, 32'd0);
        check({tag, "_flags"},    {28'd0, flags}, 32'd0);
        check({tag, "_cmp"},      {31'd0, cmp_flag}, 32'd0);
        check({tag, "_wb_done"},  {31'd0, wb_done}, 32'd0);
        check({tag, "_halted"},   {31'd0, halted}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        int w;
        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = '0;
        rd       = '0;
        mem_addr = '0;
        result   = '0;
        {zero_in, carry_in, ac_in, parity_in} = 4'b0000;

        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);
        check("por_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back add then sub.
        send(5'b00001, 3'd1, 4'h0, 16'h00FF, 4'b0100, 1, 4'd1, 8'hFF, 4'd0, 8'h00, 4'b0100, 1'b0, w);
        send(5'b00010, 3'd4, 4'h0, 16'h0000, 4'b1001, 1, 4'd4, 8'h00, 4'd0, 8'h00, 4'b1001, 1'b0, w);
        check("sub_no_stall", w, 32'd0);

        // Divide with rd=7 wraps the high byte to r0; ready low for two cycles.
        send(5'b00100, 3'd7, 4'h0, 16'h0305, 4'b0111, 3, 4'd7, 8'h05, 4'd0, 8'h03, 4'b0001, 1'b0, w);
        @(negedge clk);
        check("div_ready_wr_lo", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("div_ready_wr_hi", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("div_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Store, then compare (no writes, flags held).
        send(5'b01100, 3'd0, 4'hA, 16'h005C, 4'b1110, 2, 4'hA, 8'h5C, 4'd0, 8'h00, 4'b1000, 1'b0, w);
        send(5'b11001, 3'd0, 4'h0, 16'h0001, 4'b0111, 0, 4'd0, 8'h00, 4'd0, 8'h00, 4'b1000, 1'b1, w);
        idle(2);

        // Flag selectivity: AND keeps carry/ac from the preceding add.
        send(5'b00001, 3'd2, 4'h0, 16'h0010, 4'b0001, 1, 4'd2, 8'h10, 4'd0, 8'h00, 4'b0001, 1'b1, w);
        send(5'b00111, 3'd3, 4'h0, 16'h0011, 4'b0110, 1, 4'd3, 8'h11, 4'd0, 8'h00, 4'b0000, 1'b1, w);
        // Multiply: zero/parity only; then a carry-only op; then a jump.
        send(5'b00011, 3'd5, 4'h0, 16'hABCD, 4'b1111, 3, 4'd5, 8'hCD, 4'd6, 8'hAB, 4'b1001, 1'b1, w);
        send(5'b10000, 3'd6, 4'h0, 16'h0080, 4'b0110, 1, 4'd6, 8'h80, 4'd0, 8'h00, 4'b0100, 1'b1, w);
        send(5'b01101, 3'd1, 4'h3, 16'h00EE, 4'b1111, 0, 4'd0, 8'h00, 4'd0, 8'h00, 4'b0100, 1'b1, w);
        idle(3);
        check("mid_queues_write", wr_q.size(), 32'd0);
        check("mid_queues_retire", ret_q.size(), 32'd0);

        // Reset during WR_HI of a multiply abandons the r3 write.
        send(5'b00011, 3'd2, 4'h0, 16'h1234, 4'b0000, 3, 4'd2, 8'h34, 4'd3, 8'h12, 4'b0000, 1'b0, w);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        check("rst_mid_pending_write", wr_q.size(), 32'd1);
        check("rst_mid_pending_retire", ret_q.size(), 32'd1);
        wr_q.delete();
        ret_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", {31'd0, in_ready}, 32'd1);
        idle(3);

        // Halt with an add held valid behind it.
        send(5'b11111, 3'd0, 4'h0, 16'h0000, 4'b1111, 0, 4'd0, 8'h00, 4'd0, 8'h00, 4'b0000, 1'b0, w);
        opcode   = 5'b00001;
        rd       = 3'd1;
        result   = 16'h0077;
        in_valid = 1'b1;
        @(negedge clk);
        check("halt_wr_lo_ready", {31'd0, in_ready}, 32'd0);
        check("halt_wr_lo_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("halt_queues_write", wr_q.size(), 32'd0);
        check("halt_queues_retire", ret_q.size(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("halt_cleared", {31'd0, halted}, 32'd0);
        check("halt_ready_after", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
